// File: rtl/myproject_mul_pkg.sv
// rtl/myproject_mul_pkg.sv - shared mode codes, stage payload and parameter checks for the mul/acc pipe
package myproject_mul_pkg;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  localparam int MIN_STAGE = 1;
  localparam int MAX_STAGE = 8;

  // Control payload carried alongside the product through every pipeline slot.
  typedef struct packed {
    logic valid;
    logic mode;
    logic first;
    logic last;
  } stage_ctrl_t;

  function automatic bit widths_ok(input int din0_w, input int din1_w, input int dout_w);
    return dout_w >= din0_w + din1_w + 1;
  endfunction

  function automatic bit stages_ok(input int num_stage);
    return (num_stage >= MIN_STAGE) && (num_stage <= MAX_STAGE);
  endfunction

endpackage

// File: rtl/myproject_sat_add.sv
// rtl/myproject_sat_add.sv - signed add one bit wider than its operands, with clamp or wrap on overflow
module myproject_sat_add #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 1
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    overflow
);

  logic [WIDTH:0] wide;

  always_comb begin
    wide     = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    // Both inputs are in range, so the extra bit disagreeing with the MSB means out of range.
    overflow = wide[WIDTH] ^ wide[WIDTH-1];
    sum      = wide[WIDTH-1:0];
    if (overflow && (SATURATE != 0)) begin
      if (wide[WIDTH]) begin
        sum = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        sum = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/myproject_mul_acc_pipe.sv
// rtl/myproject_mul_acc_pipe.sv - pipelined multiplier / multiply-accumulate with valid/ready stream
module myproject_mul_acc_pipe
  import myproject_mul_pkg::*;
#(
  parameter int DIN0_WIDTH  = 3,
  parameter int DIN1_WIDTH  = 6,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 1,
  parameter int DOUT_WIDTH  = 16,
  parameter int NUM_STAGE   = 2,
  parameter int SATURATE    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_first,
  input  logic                  acc_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_ovf
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 1;

  if (!widths_ok(DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH)) begin : g_bad_width
    $error("DOUT_WIDTH must be >= DIN0_WIDTH+DIN1_WIDTH+1");
  end
  if (!stages_ok(NUM_STAGE)) begin : g_bad_stage
    $error("NUM_STAGE must be within 1..8");
  end

  logic advance;

  assign advance  = ce && (!out_valid || out_ready);
  assign in_ready = advance;

  logic signed [DIN0_WIDTH:0] op0;
  logic signed [DIN1_WIDTH:0] op1;
  logic signed [PW:0]         prod_full;
  logic signed [PW-1:0]       prod_in;

  // Unsigned operands get a zero sign bit so one signed multiply covers every mix.
  assign op0       = {(DIN0_SIGNED != 0) && din0[DIN0_WIDTH-1], din0};
  assign op1       = {(DIN1_SIGNED != 0) && din1[DIN1_WIDTH-1], din1};
  assign prod_full = op0 * op1;
  assign prod_in   = prod_full[PW-1:0];

  // Slot 0 is the live input; slots 1..NUM_STAGE-1 are registers shifting on advance.
  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stg
    stage_ctrl_t        ctrl;
    logic signed [PW-1:0] prod;

    if (k == 0) begin : g_in
      assign ctrl = {in_valid, mode, acc_first, acc_last};
      assign prod = prod_in;
    end else begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ctrl <= '0;
          prod <= '0;
        end else if (advance) begin
          ctrl <= g_stg[k-1].ctrl;
          prod <= g_stg[k-1].prod;
        end
      end
    end
  end

  stage_ctrl_t                  last_ctrl;
  logic signed [PW-1:0]         last_prod;
  logic signed [DOUT_WIDTH-1:0] prod_ext;
  logic signed [DOUT_WIDTH-1:0] acc;
  logic signed [DOUT_WIDTH-1:0] acc_base;
  logic signed [DOUT_WIDTH-1:0] acc_sum;
  logic                         acc_ovf;
  logic                         ovf_sticky;
  logic                         ovf_next;

  assign last_ctrl = g_stg[NUM_STAGE-1].ctrl;
  assign last_prod = g_stg[NUM_STAGE-1].prod;
  assign prod_ext  = DOUT_WIDTH'(last_prod);
  assign acc_base  = last_ctrl.first ? '0 : acc;
  assign ovf_next  = (last_ctrl.first ? 1'b0 : ovf_sticky) | acc_ovf;

  myproject_sat_add #(
    .WIDTH    (DOUT_WIDTH),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .a        (acc_base),
    .b        (prod_ext),
    .sum      (acc_sum),
    .overflow (acc_ovf)
  );

  // Output/accumulator stage: MUL beats bypass acc; ACC beats only surface on last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      dout       <= '0;
      dout_ovf   <= 1'b0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else if (advance) begin
      out_valid <= 1'b0;
      if (last_ctrl.valid) begin
        if (last_ctrl.mode == MODE_MUL) begin
          out_valid <= 1'b1;
          dout      <= prod_ext;
          dout_ovf  <= 1'b0;
        end else begin
          acc        <= acc_sum;
          ovf_sticky <= ovf_next;
          if (last_ctrl.last) begin
            out_valid <= 1'b1;
            dout      <= acc_sum;
            dout_ovf  <= ovf_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_myproject_mul_acc_pipe.sv
// tb/tb_myproject_mul_acc_pipe.sv - directed self-checking bench for the mul/acc pipe
module tb_myproject_mul_acc_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        mode;
  logic        in_valid;
  logic        acc_first;
  logic        acc_last;
  logic        out_ready;
  logic [2:0]  din0;
  logic [5:0]  din1;

  logic        in_ready, out_valid, dout_ovf;
  logic [15:0] dout;
  logic        in_ready_s, out_valid_s, dout_ovf_s;
  logic [9:0]  dout_s;
  logic        in_ready_w, out_valid_w, dout_ovf_w;
  logic [9:0]  dout_w;

  int checks = 0;
  int errors = 0;

  int q_dout[$], q_ovf[$], q_sat[$], q_sat_ovf[$], q_wrap[$], q_wrap_ovf[$];

  always #5 clk = ~clk;

  myproject_mul_acc_pipe u_dut (
    .clk(clk), .reset(reset), .ce(ce), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .dout_ovf(dout_ovf)
  );

  myproject_mul_acc_pipe #(.DOUT_WIDTH(10), .SATURATE(1)) u_sat10 (
    .clk(clk), .reset(reset), .ce(ce), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_s),
    .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .dout(dout_s), .dout_ovf(dout_ovf_s)
  );

  myproject_mul_acc_pipe #(.DOUT_WIDTH(10), .SATURATE(0)) u_wrap10 (
    .clk(clk), .reset(reset), .ce(ce), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_w),
    .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(out_valid_w), .out_ready(out_ready), .dout(dout_w), .dout_ovf(dout_ovf_w)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Every accepted result of all three instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && ce && out_valid && out_ready) begin
      q_dout.push_back(int'($signed(dout)));
      q_ovf.push_back(int'(dout_ovf));
      q_sat.push_back(int'($signed(dout_s)));
      q_sat_ovf.push_back(int'(dout_ovf_s));
      q_wrap.push_back(int'($signed(dout_w)));
      q_wrap_ovf.push_back(int'(dout_ovf_w));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_dout.delete(); q_ovf.delete(); q_sat.delete();
    q_sat_ovf.delete(); q_wrap.delete(); q_wrap_ovf.delete();
  endtask

  task automatic beat(input logic m, input logic [2:0] a, input logic [5:0] b,
                      input logic f, input logic l);
    int n;
    n = 0;
    mode = m; din0 = a; din1 = b; acc_first = f; acc_last = l; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    step();
    in_valid = 1'b0; acc_first = 1'b0; acc_last = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  int exp4[6] = '{1, -6, 30, -7, -128, 150};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ce = 1'b1; mode = 1'b0; in_valid = 1'b0; acc_first = 1'b0;
    acc_last = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
    repeat (2) step();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_ovf", int'(dout_ovf), 0);
    reset = 1'b0;
    step();

    // MUL latency and back-to-back
    beat(1'b0, 3'd7, 6'h20, 1'b0, 1'b0);
    beat(1'b0, 3'd5, 6'h1F, 1'b0, 1'b0);
    check("mul1_valid", int'(out_valid), 1);
    check("mul1_dout", int'(dout), 16'hFF20);
    check("mul1_ovf", int'(dout_ovf), 0);
    step();
    check("mul2_dout", int'($signed(dout)), 155);
    step();
    check("mul_bubble", int'(out_valid), 0);
    drain(2);

    // ACC 4 x 7*31
    clear_q();
    beat(1'b1, 3'd7, 6'h1F, 1'b1, 1'b0);
    beat(1'b1, 3'd7, 6'h1F, 1'b0, 1'b0);
    check("acc_b1_novalid", int'(out_valid), 0);
    beat(1'b1, 3'd7, 6'h1F, 1'b0, 1'b0);
    check("acc_b2_novalid", int'(out_valid), 0);
    beat(1'b1, 3'd7, 6'h1F, 1'b0, 1'b1);
    check("acc_b3_novalid", int'(out_valid), 0);
    step();
    check("acc_valid", int'(out_valid), 1);
    check("acc_dout", int'($signed(dout)), 868);
    check("acc_ovf", int'(dout_ovf), 0);
    drain(3);
    check("acc_count", q_dout.size(), 1);

    // ACC 3 x 7*31 into 10-bit saturating and wrapping instances
    clear_q();
    beat(1'b1, 3'd7, 6'h1F, 1'b1, 1'b0);
    beat(1'b1, 3'd7, 6'h1F, 1'b0, 1'b0);
    beat(1'b1, 3'd7, 6'h1F, 1'b0, 1'b1);
    drain(4);
    check("sat_count", q_sat.size(), 1);
    if (q_sat.size() > 0) begin
      check("acc16_dout", q_dout[0], 651);
      check("acc16_ovf", q_ovf[0], 0);
      check("sat10_dout", q_sat[0], 511);
      check("sat10_ovf", q_sat_ovf[0], 1);
      check("wrap10_dout", q_wrap[0], -373);
      check("wrap10_ovf", q_wrap_ovf[0], 1);
    end

    // Backpressure: 6 MUL beats with a 3-cycle output stall
    clear_q();
    fork
      begin
        beat(1'b0, 3'd1, 6'd1, 1'b0, 1'b0);
        beat(1'b0, 3'd2, 6'h3D, 1'b0, 1'b0);
        beat(1'b0, 3'd3, 6'd10, 1'b0, 1'b0);
        beat(1'b0, 3'd7, 6'h3F, 1'b0, 1'b0);
        beat(1'b0, 3'd4, 6'h20, 1'b0, 1'b0);
        beat(1'b0, 3'd6, 6'd25, 1'b0, 1'b0);
      end
      begin
        repeat (3) step();
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", int'(in_ready), 0);
        end
        step();
        out_ready = 1'b1;
      end
    join
    drain(6);
    check("bp_count", q_dout.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp_val%0d", i), (q_dout.size() > i) ? q_dout[i] : 32'h7fff_0000, exp4[i]);
    end

    // Reset in the middle of an ACC group
    clear_q();
    beat(1'b1, 3'd7, 6'h1F, 1'b1, 1'b0);
    beat(1'b1, 3'd7, 6'h1F, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_dout", int'(dout), 0);
    check("midrst_ovf", int'(dout_ovf), 0);
    step();
    reset = 1'b0;
    clear_q();
    beat(1'b1, 3'd3, 6'h3F, 1'b1, 1'b0);
    beat(1'b1, 3'd2, 6'd2, 1'b0, 1'b1);
    drain(4);
    check("postrst_count", q_dout.size(), 1);
    if (q_dout.size() > 0) begin
      check("postrst_dout", q_dout[0], 1);
      check("postrst_ovf", q_ovf[0], 0);
    end

    // Clock-enable freeze with a beat in flight
    beat(1'b0, 3'd3, 6'd3, 1'b0, 1'b0);
    ce = 1'b0;
    #1;
    check("ce_in_ready", int'(in_ready), 0);
    step();
    check("ce_hold1", int'(out_valid), 0);
    step();
    check("ce_hold2", int'(out_valid), 0);
    ce = 1'b1;
    step();
    check("ce_valid", int'(out_valid), 1);
    check("ce_dout", int'($signed(dout)), 9);
    drain(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
